// File: rtl/l1_block_memory_responder_pkg.sv
// rtl/l1_block_memory_responder_pkg.sv - shared widths, FSM encoding and request encodings
// Also shared with the L1 initiator side, so encodings here must stay stable.
package l1_block_memory_responder_pkg;
  localparam int WORD_W       = 16;
  localparam int ADDR_W       = 16;
  localparam int BEAT_BITS    = 3;
  localparam int BLOCK_WORDS  = 8;
  localparam int BLOCK_ADDR_W = ADDR_W - BEAT_BITS;
  localparam int LAT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_WBURST = 2'd2,
    ST_RBURST = 2'd3
  } state_e;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [BLOCK_ADDR_W-1:0] blk,
                                                  input logic [BEAT_BITS-1:0]    beat);
    return {blk, beat};
  endfunction
endpackage

// File: rtl/l1_block_memory_responder_if.sv
// rtl/l1_block_memory_responder_if.sv - L1 block request, writeback and refill bus
// master = L1 controller, slave = memory responder.
interface l1_block_memory_responder_if;
  import l1_block_memory_responder_pkg::*;

  logic                    ReqValid;
  logic                    ReqReady;
  logic                    ReqWrite;
  logic [BLOCK_ADDR_W-1:0] ReqBlockAddr;
  logic                    WrValid;
  logic [WORD_W-1:0]       WrData;
  logic                    WrReady;
  logic                    WrDone;
  logic                    RdValid;
  logic [WORD_W-1:0]       RdData;
  logic                    RdLast;
  logic                    RdReady;
  logic                    Busy;

  modport master (
    output ReqValid, ReqWrite, ReqBlockAddr, WrValid, WrData, RdReady,
    input  ReqReady, WrReady, WrDone, RdValid, RdData, RdLast, Busy
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqBlockAddr, WrValid, WrData, RdReady,
    output ReqReady, WrReady, WrDone, RdValid, RdData, RdLast, Busy
  );
endinterface

// File: rtl/l1_block_memory_responder_mem_word_array.sv
// rtl/l1_block_memory_responder_mem_word_array.sv - single-port synchronous word array
// Read register only updates on a read access, so its output holds between reads.
module mem_word_array #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/l1_block_memory_responder.sv
// rtl/l1_block_memory_responder.sv - main-memory responder for L1 block refill/writeback
// Request -> fixed latency -> 8-beat write or read burst over the block, beats 0..7.
module l1_block_memory_responder
  import l1_block_memory_responder_pkg::*;
#(
  parameter int unsigned ACCESS_LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  l1_block_memory_responder_if.slave   bus
);
  state_e                  state_d, state_q;
  logic [BLOCK_ADDR_W-1:0] blk_d, blk_q;
  logic                    write_d, write_q;
  logic [BEAT_BITS-1:0]    beat_d, beat_q;
  logic [LAT_W-1:0]        cnt_d, cnt_q;
  logic                    req_ready_d, req_ready_q;
  logic                    wr_ready_d, wr_ready_q;
  logic                    wr_done_d, wr_done_q;
  logic                    rd_valid_d, rd_valid_q;
  logic                    rd_last_d, rd_last_q;
  logic                    busy_d, busy_q;

  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [WORD_W-1:0]       mem_rdata;
  logic [BEAT_BITS-1:0]    beat_inc;

  assign beat_inc = beat_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    write_d   = write_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    wr_done_d = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = word_addr(blk_q, beat_q);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.ReqValid && req_ready_q) begin
          blk_d   = bus.ReqBlockAddr;
          write_d = bus.ReqWrite;
          beat_d  = '0;
          cnt_d   = LAT_W'(ACCESS_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Leave on the edge where the counter reaches zero; prefetch beat 0 for refills.
        if (cnt_q <= LAT_W'(1)) begin
          cnt_d = '0;
          if (write_q == REQ_WRITE) begin
            state_d = ST_WBURST;
          end else begin
            state_d  = ST_RBURST;
            mem_en   = 1'b1;
            mem_addr = word_addr(blk_q, '0);
          end
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      ST_WBURST: begin
        if (bus.WrValid) begin
          mem_en = 1'b1;
          mem_we = 1'b1;
          beat_d = beat_inc;
          if (beat_q == 3'd7) begin
            state_d   = ST_IDLE;
            wr_done_d = 1'b1;
          end
        end
      end
      ST_RBURST: begin
        if (bus.RdReady) begin
          if (beat_q == 3'd7) begin
            state_d = ST_IDLE;
          end else begin
            beat_d   = beat_inc;
            mem_en   = 1'b1;
            mem_addr = word_addr(blk_q, beat_inc);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset cycle must not commit a half-finished beat into memory.
    if (reset) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end

    req_ready_d = (state_d == ST_IDLE);
    wr_ready_d  = (state_d == ST_WBURST);
    rd_valid_d  = (state_d == ST_RBURST);
    rd_last_d   = (state_d == ST_RBURST) && (beat_d == 3'd7);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      blk_q       <= '0;
      write_q     <= REQ_READ;
      beat_q      <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      write_q     <= write_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      wr_done_q   <= wr_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      busy_q      <= busy_d;
    end
  end

  mem_word_array #(
    .AW (ADDR_W),
    .DW (WORD_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus.WrData),
    .rdata (mem_rdata)
  );

  assign bus.ReqReady = req_ready_q;
  assign bus.WrReady  = wr_ready_q;
  assign bus.WrDone   = wr_done_q;
  assign bus.RdValid  = rd_valid_q;
  assign bus.RdData   = mem_rdata;
  assign bus.RdLast   = rd_last_q;
  assign bus.Busy     = busy_q;
endmodule
